// File: rtl/mymqp_axil_reg_slave.sv
// mymqp_axil_reg_slave: AXI4-Lite register slave with NUM_REGS 32-bit read/write registers.
// Write and read channels run as independent two-state FSMs; every output is registered.
// Optional feature macro: MYMQP_AXIL_SLVERR_EN. When it is defined, out-of-range accesses
// answer SLVERR (2'b10); otherwise they answer OKAY. In both cases writes are dropped and
// reads return zero.
module mymqp_axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // First byte address past the register block; wider than the address bus so it always fits.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * 4);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef MYMQP_AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Write channel state
    w_state_t                r_wstate, w_wstate_next;
    logic                    r_aw_held, w_aw_held_next;
    logic                    r_w_held, w_w_held_next;
    logic [ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_next;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
    logic [STRB_W-1:0]       r_wstrb, w_wstrb_next;
    logic                    r_awready, w_awready_next;
    logic                    r_wready, w_wready_next;
    logic                    r_bvalid, w_bvalid_next;
    logic [1:0]              r_bresp, w_bresp_next;

    // Read channel state
    r_state_t                r_rstate, w_rstate_next;
    logic                    r_arready, w_arready_next;
    logic                    r_rvalid, w_rvalid_next;
    logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_next;
    logic [1:0]              r_rresp, w_rresp_next;

    // Register file and its registered copy presented on reg_out
    logic [DATA_WIDTH-1:0]   r_regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0]   r_shadow [NUM_REGS];
    logic [NUM_REGS-1:0]     w_reg_we;

    logic                    w_aw_hs, w_w_hs, w_ar_hs;
    logic                    w_commit;
    logic                    w_wr_hit, w_rd_hit;
    logic [IDX_W-1:0]        w_wr_idx, w_rd_idx;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // Protection bits carry no meaning for this block.
    logic                    w_unused_prot;
    assign w_unused_prot = ^{AWPROT, ARPROT};

    assign w_aw_hs  = AWVALID && r_awready;
    assign w_w_hs   = WVALID && r_wready;
    assign w_ar_hs  = ARVALID && r_arready;
    // A write commits on the first edge where both halves are held and no response is pending.
    assign w_commit = (r_wstate == W_IDLE) && r_aw_held && r_w_held;

    assign w_wr_hit = ({1'b0, r_awaddr} < ADDR_LIMIT);
    assign w_rd_hit = ({1'b0, ARADDR} < ADDR_LIMIT);
    assign w_wr_idx = r_awaddr[IDX_W+1:2];
    assign w_rd_idx = ARADDR[IDX_W+1:2];

    // Read mux: out-of-range addresses read as zero.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_hit) begin
            w_rd_data = r_regs[w_rd_idx];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_reg_we[gi] = w_commit && w_wr_hit && (w_wr_idx == IDX_W'(gi));

            // Byte-masked register update on the commit edge
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    r_regs[gi] <= '0;
                end else if (w_reg_we[gi]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (r_wstrb[b]) begin
                            r_regs[gi][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end

            // reg_out follows the register file one cycle later
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    r_shadow[gi] <= '0;
                end else begin
                    r_shadow[gi] <= r_regs[gi];
                end
            end

            assign reg_out[DATA_WIDTH*gi +: DATA_WIDTH] = r_shadow[gi];
        end
    endgenerate

    // Write channel state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate  <= w_wstate_next;
            r_aw_held <= w_aw_held_next;
            r_w_held  <= w_w_held_next;
            r_awaddr  <= w_awaddr_next;
            r_wdata   <= w_wdata_next;
            r_wstrb   <= w_wstrb_next;
            r_awready <= w_awready_next;
            r_wready  <= w_wready_next;
            r_bvalid  <= w_bvalid_next;
            r_bresp   <= w_bresp_next;
        end
    end

    // Write channel next-state: collect AW and W in any order, commit, then hold B until accepted
    always_comb begin
        w_wstate_next  = r_wstate;
        w_aw_held_next = r_aw_held;
        w_w_held_next  = r_w_held;
        w_awaddr_next  = r_awaddr;
        w_wdata_next   = r_wdata;
        w_wstrb_next   = r_wstrb;
        w_awready_next = r_awready;
        w_wready_next  = r_wready;
        w_bvalid_next  = r_bvalid;
        w_bresp_next   = r_bresp;
        case (r_wstate)
            W_IDLE: begin
                if (w_commit) begin
                    w_bvalid_next  = 1'b1;
                    w_bresp_next   = w_wr_hit ? RESP_OKAY : RESP_OOR;
                    w_awready_next = 1'b0;
                    w_wready_next  = 1'b0;
                    w_wstate_next  = W_RESP;
                end else begin
                    if (w_aw_hs) begin
                        w_aw_held_next = 1'b1;
                        w_awaddr_next  = AWADDR;
                    end
                    if (w_w_hs) begin
                        w_w_held_next = 1'b1;
                        w_wdata_next  = WDATA;
                        w_wstrb_next  = WSTRB;
                    end
                    w_awready_next = !w_aw_held_next;
                    w_wready_next  = !w_w_held_next;
                end
            end
            W_RESP: begin
                if (r_bvalid && BREADY) begin
                    w_bvalid_next  = 1'b0;
                    w_bresp_next   = RESP_OKAY;
                    w_aw_held_next = 1'b0;
                    w_w_held_next  = 1'b0;
                    w_awready_next = 1'b1;
                    w_wready_next  = 1'b1;
                    w_wstate_next  = W_IDLE;
                end
            end
            default: begin
                w_wstate_next = W_IDLE;
            end
        endcase
    end

    // Read channel state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_next;
            r_arready <= w_arready_next;
            r_rvalid  <= w_rvalid_next;
            r_rdata   <= w_rdata_next;
            r_rresp   <= w_rresp_next;
        end
    end

    // Read channel next-state: capture on AR handshake, hold R until accepted
    always_comb begin
        w_rstate_next  = r_rstate;
        w_arready_next = r_arready;
        w_rvalid_next  = r_rvalid;
        w_rdata_next   = r_rdata;
        w_rresp_next   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rvalid_next  = 1'b1;
                    w_rdata_next   = w_rd_data;
                    w_rresp_next   = w_rd_hit ? RESP_OKAY : RESP_OOR;
                    w_arready_next = 1'b0;
                    w_rstate_next  = R_DATA;
                end else begin
                    w_arready_next = 1'b1;
                end
            end
            R_DATA: begin
                if (r_rvalid && RREADY) begin
                    w_rvalid_next  = 1'b0;
                    w_arready_next = 1'b1;
                    w_rstate_next  = R_IDLE;
                end
            end
            default: begin
                w_rstate_next = R_IDLE;
            end
        endcase
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

endmodule

// File: tb/tb_mymqp_axil_reg_slave.sv
// Testbench for mymqp_axil_reg_slave: directed scenarios plus randomized traffic checked
// against a simple array model of the register block.
module tb_mymqp_axil_reg_slave;

    localparam int NREGS = 4;
`ifdef MYMQP_AXIL_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         ARESET;
    logic [4:0]   AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [4:0]   ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] reg_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [NREGS];

    mymqp_axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(NREGS)) dut (
        .ACLK(clk), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_write(input logic [4:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] mask;
        int idx;
        if (int'(addr) >= NREGS * 4) return;
        idx  = int'(addr) / 4;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        model[idx] = (model[idx] & ~mask) | (data & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (int'(addr) >= NREGS * 4) return 32'h0;
        return model[int'(addr) / 4];
    endfunction

    function automatic logic [1:0] model_resp(input logic [4:0] addr);
        return (int'(addr) >= NREGS * 4) ? EXP_OOR : 2'b00;
    endfunction

    // ---------------- bus drivers (start and end at posedge+1) ----------------
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_pend = 1, w_pend = 1, aw_fire, w_fire, got_b = 0;
        int cyc = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; BREADY = 1'b1; resp = 2'bxx;
        while ((aw_pend || w_pend) && cyc < 64) begin
            AWVALID = aw_pend && (cyc >= aw_dly);
            WVALID  = w_pend && (cyc >= w_dly);
            @(negedge clk);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge clk); #1;
            if (aw_fire) aw_pend = 0;
            if (w_fire)  w_pend = 0;
            cyc++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        while (!got_b && cyc < 128) begin
            @(negedge clk);
            if (BVALID) begin resp = BRESP; got_b = 1; end
            @(posedge clk); #1;
            cyc++;
        end
        BREADY = 1'b0;
        n_checks++;
        if (!got_b) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h: got no B response, required one within 128 cycles", addr);
        end
        $display("wr addr=%h data=%h strb=%b bresp=%b", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit fired = 0, got = 0;
        int cyc = 0;
        ARADDR = addr; RREADY = 1'b1; data = 'x; resp = 'x;
        while (!fired && cyc < 64) begin
            ARVALID = 1'b1;
            @(negedge clk);
            fired = ARREADY;
            @(posedge clk); #1;
            cyc++;
        end
        ARVALID = 1'b0;
        while (!got && cyc < 128) begin
            @(negedge clk);
            if (RVALID) begin data = RDATA; resp = RRESP; got = 1; end
            @(posedge clk); #1;
            cyc++;
        end
        RREADY = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h: got no R response, required one within 128 cycles", addr);
        end
        $display("rd addr=%h rdata=%h rresp=%b", addr, data, resp);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        ARESET = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, reg_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h reg_out=%h, required all zero",
                     AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, reg_out);
        end
        @(posedge clk); #1;
        ARESET = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b%b%b before first edge, required 000", AWREADY, WREADY, ARREADY);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready_rise: got %b%b%b, required 111", AWREADY, WREADY, ARREADY);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    endtask

    task automatic test_basic;
        logic [31:0] vals [4];
        logic [31:0] d;
        logic [1:0]  r;
        vals = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), vals[i], 4'hF, 0, 0, r);
            model_write(5'(i * 4), vals[i], 4'hF);
            n_checks++;
            if (r !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_bresp reg%0d: got %b, required 00", i, r);
            end
            axi_read(5'(i * 4), d, r);
            n_checks++;
            if (d !== vals[i] || r !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_read reg%0d: got %h/%b, required %h/00", i, d, r, vals[i]);
            end
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h04, 32'h12345678, 4'b0101, 0, 0, r);
        model_write(5'h04, 32'h12345678, 4'b0101);
        axi_read(5'h04, d, r);
        n_checks++;
        if (d !== 32'hab340078 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL strobe_merge: got %h/%b, required ab340078/00", d, r);
        end
    endtask

    task automatic test_w_before_aw;
        logic [31:0] data, d;
        logic [1:0]  r;
        data = $urandom;
        AWADDR = 5'h0C; WDATA = data; WSTRB = 4'hF; BREADY = 1'b0;
        WVALID = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        WVALID = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({WREADY, AWREADY, BVALID} !== 3'b010) begin
                n_fail++;
                $display("FAIL wfirst_wait: got wready=%b awready=%b bvalid=%b, required 0/1/0", WREADY, AWREADY, BVALID);
            end
            @(posedge clk); #1;
        end
        AWVALID = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        @(negedge clk);
        n_checks++;
        if (BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_bvalid_early: got %b one cycle after AW handshake, required 0", BVALID);
        end
        @(posedge clk); #1;
        model_write(5'h0C, data, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b1_00_0_0) begin
                n_fail++;
                $display("FAIL wfirst_bhold cycle%0d: got bvalid=%b bresp=%b awready=%b wready=%b, required 1/00/0/0",
                         i, BVALID, BRESP, AWREADY, WREADY);
            end
            @(posedge clk); #1;
        end
        BREADY = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        BREADY = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            n_fail++;
            $display("FAIL wfirst_after_b: got bvalid=%b awready=%b wready=%b, required 0/1/1", BVALID, AWREADY, WREADY);
        end
        @(posedge clk); #1;
        axi_read(5'h0C, d, r);
        n_checks++;
        if (d !== model[3] || r !== 2'b00) begin
            n_fail++;
            $display("FAIL wfirst_read: got %h/%b, required %h/00", d, r, model[3]);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h14, 32'hCAFEF00D, 4'hF, 0, 0, r);
        model_write(5'h14, 32'hCAFEF00D, 4'hF);
        n_checks++;
        if (r !== EXP_OOR) begin
            n_fail++;
            $display("FAIL oor_bresp: got %b, required %b", r, EXP_OOR);
        end
        axi_read(5'h14, d, r);
        n_checks++;
        if (d !== 32'h0 || r !== EXP_OOR) begin
            n_fail++;
            $display("FAIL oor_read: got %h/%b, required 00000000/%b", d, r, EXP_OOR);
        end
        for (int i = 0; i < NREGS; i++) begin
            axi_read(5'(i * 4), d, r);
            n_checks++;
            if (d !== model[i] || r !== 2'b00) begin
                n_fail++;
                $display("FAIL oor_regs_intact reg%0d: got %h/%b, required %h/00", i, d, r, model[i]);
            end
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] old, newd, d;
        logic [1:0]  r;
        // AR, AW and W all presented together
        old = model[2];
        AWADDR = 5'h08; ARADDR = 5'h08; WDATA = 32'h55AA55AA; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({BVALID, RVALID, RRESP} !== 4'b0100 || RDATA !== old) begin
            n_fail++;
            $display("FAIL same_k1: got bvalid=%b rvalid=%b rdata=%h rresp=%b, required 0/1/%h/00", BVALID, RVALID, RDATA, RRESP, old);
        end
        @(posedge clk); #1;
        model_write(5'h08, 32'h55AA55AA, 4'hF);
        @(negedge clk);
        n_checks++;
        if ({BVALID, BRESP, RVALID} !== 4'b1001 || RDATA !== old || reg_out[95:64] !== old) begin
            n_fail++;
            $display("FAIL same_k2: got bvalid=%b bresp=%b rvalid=%b rdata=%h reg_out2=%h, required 1/00/1/%h/%h",
                     BVALID, BRESP, RVALID, RDATA, reg_out[95:64], old, old);
        end
        @(posedge clk); #1;
        BREADY = 1'b0;
        @(negedge clk);
        n_checks++;
        if (reg_out[95:64] !== model[2]) begin
            n_fail++;
            $display("FAIL same_reg_out: got %h, required %h", reg_out[95:64], model[2]);
        end
        RREADY = 1'b1;
        @(posedge clk); #1;
        RREADY = 1'b0;
        axi_read(5'h08, d, r);
        n_checks++;
        if (d !== model[2] || r !== 2'b00) begin
            n_fail++;
            $display("FAIL same_next_read: got %h/%b, required %h/00", d, r, model[2]);
        end
        // Read captured on the very edge the write commits
        old = model[2];
        newd = $urandom;
        WDATA = newd; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b1; ARADDR = 5'h08;
        @(negedge clk);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        model_write(5'h08, newd, 4'hF);
        @(negedge clk);
        n_checks++;
        if ({BVALID, RVALID} !== 2'b11 || RDATA !== old) begin
            n_fail++;
            $display("FAIL commit_edge_read: got bvalid=%b rvalid=%b rdata=%h, required 1/1/%h", BVALID, RVALID, RDATA, old);
        end
        RREADY = 1'b1;
        @(posedge clk); #1;
        RREADY = 1'b0; BREADY = 1'b0;
        axi_read(5'h08, d, r);
        n_checks++;
        if (d !== model[2]) begin
            n_fail++;
            $display("FAIL commit_edge_next: got %h, required %h", d, model[2]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d, data;
        logic [1:0]  r;
        int n;
        data = $urandom | 32'h1;
        AWADDR = 5'h00; WDATA = data; WSTRB = 4'hF; BREADY = 1'b0;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (BVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_bvalid: got %b, required 1 before reset", BVALID);
        end
        ARESET = 1'b1;
        @(posedge clk); #1;
        ARESET = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b0 || reg_out !== '0) begin
            n_fail++;
            $display("FAIL rstmid_state: got bv=%b rv=%b rdy=%b%b%b reg_out=%h, required all zero",
                     BVALID, RVALID, AWREADY, WREADY, ARREADY, reg_out);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREGS; i++) begin
            axi_read(5'(i * 4), d, r);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL rstmid_zero reg%0d: got %h, required 00000000", i, d);
            end
        end
        data = $urandom;
        axi_write(5'h04, data, 4'hF, 1, 0, r);
        model_write(5'h04, data, 4'hF);
        axi_read(5'h04, d, r);
        n_checks++;
        if (d !== model[1] || r !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_rewrite: got %h/%b, required %h/00", d, r, model[1]);
        end
    endtask

    task automatic test_random;
        logic [4:0]  addr;
        logic [31:0] data, d;
        logic [3:0]  strb;
        logic [1:0]  r;
        for (int t = 0; t < 40; t++) begin
            addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), r);
                model_write(addr, data, strb);
                n_checks++;
                if (r !== model_resp(addr)) begin
                    n_fail++;
                    $display("FAIL rand_bresp t%0d addr=%h: got %b, required %b", t, addr, r, model_resp(addr));
                end
            end else begin
                axi_read(addr, d, r);
                n_checks++;
                if (d !== model_read(addr) || r !== model_resp(addr)) begin
                    n_fail++;
                    $display("FAIL rand_read t%0d addr=%h: got %h/%b, required %h/%b",
                             t, addr, d, r, model_read(addr), model_resp(addr));
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) begin
            n_checks++;
            if (reg_out[32*i +: 32] !== model[i]) begin
                n_fail++;
                $display("FAIL rand_reg_out reg%0d: got %h, required %h", i, reg_out[32*i +: 32], model[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        test_reset;
        test_basic;
        test_strobe;
        test_w_before_aw;
        test_out_of_range;
        test_same_cycle;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
